ob_host: RTL and testbench

OB_HOST -- requirements
Module: ob_host

---
 rtl/ob_host.sv | 153 +++++++++++++++
 tb/tb_ob_host.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ob_host.sv
// Host-side shim for the order book: registers commands, limits how many are in flight,
// buffers responses in a small FIFO, and runs a watchdog, sticky errors and a drain mode.
package ob_pkg;
  typedef struct packed {
    logic [7:0]  uid;
    logic        side;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  typedef struct packed {
    logic [7:0] uid;
    logic [1:0] status;
  } rsp_t;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
endpackage

module ob_host
  import ob_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 host_cmd_vld,
  input  cmd_t                                 host_cmd,
  output logic                                 host_cmd_rdy,
  output logic                                 cmd_vld_r,
  output cmd_t                                 cmd_r,
  input  logic                                 cmd_full_r,
  input  logic                                 rsp_vld,
  input  rsp_t                                 rsp,
  output logic                                 rsp_accept,
  output logic                                 host_rsp_vld,
  output rsp_t                                 host_rsp,
  input  logic                                 host_rsp_accept,
  input  logic                                 flush_req,
  output logic                                 flush_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_timeout,
  output logic                                 err_unexp,
  input  logic                                 err_clr,
  output state_t                               state
);
  // Handshakes: a transfer happens in a cycle where valid and ready/accept are both 1
  // at the rising edge; ready/accept depend only on registered state and cmd_full_r.
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic          issue;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  rsp_t          mem [RSP_DEPTH];
  logic [WW-1:0] wd;
  logic          wd_clear;
  logic          wd_hit;
  logic          unexp;

  assign fifo_full    = (count == CW'(RSP_DEPTH));
  assign fifo_empty   = (count == '0);
  assign rsp_accept   = ~fifo_full;
  assign host_rsp_vld = ~fifo_empty;
  assign host_rsp     = mem[rd_ptr];
  assign push         = rsp_vld & rsp_accept;
  assign pop          = host_rsp_vld & host_rsp_accept;

  assign host_cmd_rdy = (state == RUN) & ~cmd_full_r & (outstanding < OW'(MAX_OUTSTANDING));
  assign issue        = host_cmd_vld & host_cmd_rdy;
  assign unexp        = push & (outstanding == '0);

  assign wd_clear = (outstanding == '0) | push;
  // Fire only on the step into the limit so a cleared error stays clear while saturated.
  assign wd_hit   = ~wd_clear & (wd == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld_r <= 1'b0;
      cmd_r     <= '0;
    end else begin
      cmd_vld_r <= issue;
      if (issue) cmd_r <= host_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (issue & ~push) begin
      outstanding <= outstanding + OW'(1);
    end else if (push & ~issue & (outstanding != '0)) begin
      outstanding <= outstanding - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rsp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push & ~pop)      count <= count + CW'(1);
      else if (pop & ~push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd          <= '0;
      err_timeout <= 1'b0;
      err_unexp   <= 1'b0;
    end else begin
      if (wd_clear)                      wd <= '0;
      else if (wd != WW'(TIMEOUT_CYCLES)) wd <= wd + WW'(1);
      err_timeout <= wd_hit | (err_timeout & ~err_clr);
      err_unexp   <= unexp  | (err_unexp   & ~err_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        RUN: if (flush_req) state <= DRAIN;
        DRAIN: begin
          if ((outstanding == '0) && fifo_empty && !cmd_vld_r) begin
            state      <= RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_ob_host.sv
// Directed bench for ob_host with default parameters (4 outstanding, 2-deep FIFO, 1024-cycle watchdog).
module tb_ob_host;
  import ob_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_cmd_vld;
  cmd_t       host_cmd;
  logic       host_cmd_rdy;
  logic       cmd_vld_r;
  cmd_t       cmd_r;
  logic       cmd_full_r;
  logic       rsp_vld;
  rsp_t       rsp;
  logic       rsp_accept;
  logic       host_rsp_vld;
  rsp_t       host_rsp;
  logic       host_rsp_accept;
  logic       flush_req;
  logic       flush_done;
  logic [2:0] outstanding;
  logic       err_timeout;
  logic       err_unexp;
  logic       err_clr;
  state_t     state;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  always #5 clk = ~clk;

  ob_host dut (
    .clk(clk), .rst(rst),
    .host_cmd_vld(host_cmd_vld), .host_cmd(host_cmd), .host_cmd_rdy(host_cmd_rdy),
    .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept),
    .host_rsp_vld(host_rsp_vld), .host_rsp(host_rsp), .host_rsp_accept(host_rsp_accept),
    .flush_req(flush_req), .flush_done(flush_done), .outstanding(outstanding),
    .err_timeout(err_timeout), .err_unexp(err_unexp), .err_clr(err_clr), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic vld, input logic [7:0] uid);
    host_cmd_vld   = vld;
    host_cmd.uid   = uid;
    host_cmd.side  = uid[0];
    host_cmd.price = 16'h1000 + 16'(uid);
    host_cmd.qty   = 16'd10;
  endtask

  task automatic set_rsp(input logic vld, input logic [7:0] uid);
    rsp_vld    = vld;
    rsp.uid    = uid;
    rsp.status = 2'd1;
  endtask

  initial begin
    rst = 1'b1;
    set_cmd(1'b0, 8'd0);
    set_rsp(1'b0, 8'd0);
    cmd_full_r = 1'b0; host_rsp_accept = 1'b0; flush_req = 1'b0; err_clr = 1'b0;
    repeat (2) step();

    check("rst_cmd_vld_r", 32'(cmd_vld_r), 0);
    check("rst_cmd_r", 32'(cmd_r.uid), 0);
    check("rst_host_rsp_vld", 32'(host_rsp_vld), 0);
    check("rst_rsp_accept", 32'(rsp_accept), 1);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_errs", 32'({err_timeout, err_unexp}), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    check("rst_state", 32'(state), 32'(RUN));
    rst = 1'b0;
    step();

    // Four back-to-back issues fill the outstanding budget.
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 8'(i + 1));
      #1;
      check("b2b_rdy", 32'(host_cmd_rdy), 1);
      step();
      check("b2b_cmd_vld_r", 32'(cmd_vld_r), 1);
      check("b2b_cmd_r", 32'(cmd_r.uid), 32'(i + 1));
      check("b2b_outstanding", 32'(outstanding), 32'(i + 1));
    end
    check("b2b_5th_rdy", 32'(host_cmd_rdy), 0);
    set_cmd(1'b0, 8'd5);
    step();
    check("b2b_vld_drop", 32'(cmd_vld_r), 0);
    check("b2b_cmd_hold", 32'(cmd_r.uid), 4);
    check("b2b_out_hold", 32'(outstanding), 4);

    // FIFO fills with two responses, then drains in order.
    set_rsp(1'b1, 8'd1); step();
    set_rsp(1'b1, 8'd2); step();
    check("fifo_head1", 32'(host_rsp.uid), 1);
    set_rsp(1'b1, 8'd3);
    #1;
    check("fifo_full_acc", 32'(rsp_accept), 0);
    step();
    check("fifo_full_out", 32'(outstanding), 2);
    host_rsp_accept = 1'b1;
    #1;
    check("fifo_pop_no_bypass", 32'(rsp_accept), 0);
    step();
    check("fifo_acc_after_pop", 32'(rsp_accept), 1);
    check("fifo_head2", 32'(host_rsp.uid), 2);
    step();
    check("fifo_head3_wrap", 32'(host_rsp.uid), 3);
    check("fifo_out1", 32'(outstanding), 1);
    set_rsp(1'b1, 8'd4); step();
    check("fifo_head4", 32'(host_rsp.uid), 4);
    check("fifo_out0", 32'(outstanding), 0);
    set_rsp(1'b0, 8'd0); step();
    check("fifo_empty", 32'(host_rsp_vld), 0);
    check("fifo_no_unexp", 32'(err_unexp), 0);
    host_rsp_accept = 1'b0;

    // Backpressure from the order book.
    set_cmd(1'b1, 8'd9); cmd_full_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_rdy", 32'(host_cmd_rdy), 0);
      step();
      check("full_no_issue", 32'(cmd_vld_r), 0);
    end
    cmd_full_r = 1'b0;
    #1;
    check("unfull_rdy", 32'(host_cmd_rdy), 1);
    step();
    check("unfull_issue", 32'(cmd_vld_r), 1);
    check("unfull_uid", 32'(cmd_r.uid), 9);
    check("unfull_out", 32'(outstanding), 1);

    // Issue and response accept in the same cycle.
    set_cmd(1'b1, 8'd10); set_rsp(1'b1, 8'd9); host_rsp_accept = 1'b1;
    step();
    check("same_cycle_out", 32'(outstanding), 1);
    set_cmd(1'b0, 8'd0); set_rsp(1'b1, 8'd10); step();
    check("same_cycle_out0", 32'(outstanding), 0);
    set_rsp(1'b0, 8'd0); step();
    check("same_cycle_empty", 32'(host_rsp_vld), 0);
    host_rsp_accept = 1'b0;

    // Watchdog.
    set_cmd(1'b1, 8'd20); step();
    set_cmd(1'b0, 8'd0);
    repeat (1019) step();
    check("wd_not_yet", 32'(err_timeout), 0);
    repeat (10) step();
    check("wd_timeout", 32'(err_timeout), 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("wd_clr", 32'(err_timeout), 0);
    step();
    check("wd_stays_clr", 32'(err_timeout), 0);
    set_rsp(1'b1, 8'd20); host_rsp_accept = 1'b1; step();
    set_rsp(1'b0, 8'd0); step();
    check("wd_out0", 32'(outstanding), 0);
    host_rsp_accept = 1'b0;

    // Flush with three in flight; flush_req held during drain is ignored.
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 8'(30 + i)); step();
    end
    set_cmd(1'b0, 8'd0);
    check("flush_out3", 32'(outstanding), 3);
    flush_req = 1'b1; step();
    check("flush_state_drain", 32'(state), 32'(DRAIN));
    check("flush_rdy0", 32'(host_cmd_rdy), 0);
    host_rsp_accept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rsp(1'b1, 8'(30 + i)); step();
    end
    set_rsp(1'b0, 8'd0); flush_req = 1'b0; step();
    check("flush_still_drain", 32'(state), 32'(DRAIN));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (flush_done) pulses++;
    end
    check("flush_pulses", 32'(pulses), 1);
    check("flush_state_run", 32'(state), 32'(RUN));
    check("flush_rdy1", 32'(host_cmd_rdy), 1);
    host_rsp_accept = 1'b0;

    // Unexpected response.
    set_rsp(1'b1, 8'd50); step();
    set_rsp(1'b0, 8'd0);
    check("unexp_set", 32'(err_unexp), 1);
    check("unexp_out0", 32'(outstanding), 0);
    check("unexp_visible", 32'({host_rsp_vld, host_rsp.uid}), 32'({1'b1, 8'd50}));
    err_clr = 1'b1; step();
    check("unexp_clr", 32'(err_unexp), 0);
    set_rsp(1'b1, 8'd51); step();
    err_clr = 1'b0; set_rsp(1'b0, 8'd0);
    check("unexp_set_wins", 32'(err_unexp), 1);
    host_rsp_accept = 1'b1; repeat (2) step(); host_rsp_accept = 1'b0;
    check("unexp_drained", 32'(host_rsp_vld), 0);

    // Reset mid-operation.
    set_cmd(1'b1, 8'd60); step();
    set_cmd(1'b1, 8'd61); step();
    set_cmd(1'b0, 8'd0); set_rsp(1'b1, 8'd60); step();
    set_rsp(1'b0, 8'd0);
    check("pre_rst_buf", 32'(host_rsp_vld), 1);
    rst = 1'b1; #1;
    check("mid_rst_out", 32'(outstanding), 0);
    check("mid_rst_fifo", 32'(host_rsp_vld), 0);
    check("mid_rst_unexp", 32'(err_unexp), 0);
    rst = 1'b0; step();
    set_rsp(1'b1, 8'd61); step();
    set_rsp(1'b0, 8'd0);
    check("post_rst_unexp", 32'(err_unexp), 1);
    check("post_rst_out", 32'(outstanding), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
